seq_pattern_tx: RTL



---
 rtl/seq_pattern_pkg.sv | 13 +
 rtl/seq_pattern_tx.sv | 119 +++++++++++
 2 files changed

// File: rtl/seq_pattern_pkg.sv
// Shared encodings for the serial pattern transmitter and its users.
package seq_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAPS = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [2:0] PAT_101 = 3'b101;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first a programmed
// number of times, with forced-zero gap bits between repetitions.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int unsigned PAT_W = 3,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             data,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  state_t             state, state_n;
  logic [PAT_W-1:0]   pat_q, pat_n;
  logic [PAT_W-1:0]   shift_q, shift_n;
  logic [BIT_W-1:0]   bit_q, bit_n;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic [CNT_W-1:0]   rep_q, rep_n;
  logic               data_n, valid_n, busy_n, done_n;

  // State, datapath and output registers; outputs are precomputed from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pat_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      data    <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pat_q   <= pat_n;
      shift_q <= shift_n;
      bit_q   <= bit_n;
      gap_q   <= gap_n;
      rep_q   <= rep_n;
      data    <= data_n;
      valid   <= valid_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_n = state;
    pat_n   = pat_q;
    shift_n = shift_q;
    bit_n   = bit_q;
    gap_n   = gap_q;
    rep_n   = rep_q;

    unique case (state)
      IDLE: begin
        if (start && (reps != '0)) begin
          pat_n   = pattern;
          shift_n = pattern;
          rep_n   = reps;
          bit_n   = BIT_W'(PAT_W - 1);
          state_n = SEND;
        end
      end
      SEND: begin
        shift_n = shift_q << 1;
        if (bit_q == '0) begin
          rep_n = rep_q - CNT_W'(1);
          if (rep_n == '0) begin
            state_n = DONE;
          end else if (GAP > 0) begin
            gap_n   = GAP_W'(GAP - 1);
            state_n = GAPS;
          end else begin
            // Back-to-back repetition: reload without leaving SEND.
            shift_n = pat_q;
            bit_n   = BIT_W'(PAT_W - 1);
          end
        end else begin
          bit_n = bit_q - BIT_W'(1);
        end
      end
      GAPS: begin
        if (gap_q == '0) begin
          shift_n = pat_q;
          bit_n   = BIT_W'(PAT_W - 1);
          state_n = SEND;
        end else begin
          gap_n = gap_q - GAP_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    data_n  = (state_n == SEND) ? shift_n[PAT_W-1] : 1'b0;
    valid_n = (state_n == SEND) || (state_n == GAPS);
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == DONE);
  end

endmodule
